rsa_modexp_core: RTL and testbench

- Parametrised Montgomery modular-exponentiation engine: computes RES = M^E mod N for W-bit operands.
- Byte-wide register interface with the same selection scheme as the existing RSA block: reg_sel 0 = RES (read), 1 = M, 2 = E, 3 = N.
- Adds what the existing block lacks:
  - explicit start/busy/done handshake,
  - odd-modulus check,
  - R^2 precomputation,
  - final conversion out of the Montgomery domain,
  - deterministic latency.

---
 rtl/rsa_pkg.sv | 11 +
 rtl/rsa_modexp_core_mont_mul.sv | 49 ++++
 rtl/rsa_modexp_core.sv | 106 ++++++++++
 tb/tb_rsa_modexp_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rsa_pkg: register-select codes, FSM states and latency helper for the modexp core
package rsa_pkg;
    localparam logic [1:0] RSEL_RES = 2'd0;
    localparam logic [1:0] RSEL_M   = 2'd1;
    localparam logic [1:0] RSEL_E   = 2'd2;
    localparam logic [1:0] RSEL_N   = 2'd3;
    typedef enum logic [2:0] {IDLE, CHECK, PRE, TOMONT, EXP, FINAL} state_t;
    function automatic int unsigned busy_cycles(input int unsigned w, input logic odd_n);
        return odd_n ? 1 + 2 * w + (w + 2) * (w + 2) : 1;
    endfunction
endpackage

// File: rtl/rsa_modexp_core_mont_mul.sv
// mont_mul: bit-serial Montgomery product a*b*2^-W mod n, result valid W+2 cycles after go
module mont_mul #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] res,
    output logic         valid
);
    localparam int CW = $clog2(W + 1);
    logic [W-1:0]  a_q, b_q;
    logic [W+1:0]  s, t, u;
    logic [CW-1:0] cnt;
    logic          run;
    // s stays below 2n, so W+2 bits hold s + b + n without overflow
    always_comb begin
        t = s + (a_q[0] ? {2'b00, b_q} : '0);
        u = t + (t[0] ? {2'b00, n} : '0);
    end
    assign res   = W'((s >= {2'b00, n}) ? s - {2'b00, n} : s);
    assign valid = run && cnt == CW'(W);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q <= '0;
            b_q <= '0;
            s   <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (go) begin
            a_q <= a;
            b_q <= b;
            s   <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            if (valid) begin
                run <= 1'b0;
            end else begin
                s   <= u >> 1;
                a_q <= a_q >> 1;
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: Montgomery M^E mod N engine with byte register interface and start/busy/done handshake
module rsa_modexp_core
    import rsa_pkg::*;
#(
    parameter int W  = 256,
    parameter int AW = $clog2(W / 8)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          oe,
    input  logic [1:0]    reg_sel,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    data_i,
    output logic [7:0]    data_o,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error
);
    localparam int CW = $clog2(2 * W);
    localparam int KW = $clog2(W);
    localparam int NB = W / 8;
    state_t        state, nxt;
    logic [W-1:0]  m, e, n, res, a, t, x, x_next, a0, b0, r0, r1;
    logic [W:0]    x2;
    logic [CW-1:0] cnt;
    logic [KW-1:0] k;
    logic          err_q, go0, go1, v0, v1, mm_done, addr_ok, wr_ok;
    int            bo;
    assign busy    = state != IDLE;
    assign error   = err_q | (state == CHECK && !n[0]);
    assign addr_ok = int'(addr) < NB;
    assign wr_ok   = !we && !busy && addr_ok;
    assign bo      = 8 * int'(addr);
    assign mm_done = v0 && (state != EXP || v1);
    assign x2      = {x, 1'b0};
    assign x_next  = W'((x2 >= {1'b0, n}) ? x2 - {1'b0, n} : x2);
    // T holds R^2 at the end of PRE, so the TOMONT product needs no extra register
    assign a0      = state == TOMONT ? m : a;
    assign b0      = state == FINAL ? W'(1) : t;
    assign go0     = (state inside {TOMONT, EXP, FINAL}) && cnt == '0;
    assign go1     = state == EXP && cnt == '0;
    mont_mul #(.W(W)) u_mul_a (
        .clk(clk), .reset(reset), .go(go0), .a(a0), .b(b0), .n(n), .res(r0), .valid(v0)
    );
    mont_mul #(.W(W)) u_mul_t (
        .clk(clk), .reset(reset), .go(go1), .a(t), .b(t), .n(n), .res(r1), .valid(v1)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end
    always_comb begin
        nxt  = state;
        done = 1'b0;
        case (state)
            IDLE:    nxt = start ? CHECK : IDLE;
            CHECK: begin
                nxt  = n[0] ? PRE : IDLE;
                done = !n[0];
            end
            PRE:     nxt = cnt == CW'(2 * W - 1) ? TOMONT : PRE;
            TOMONT:  nxt = mm_done ? EXP : TOMONT;
            EXP:     nxt = (mm_done && k == KW'(W - 1)) ? FINAL : EXP;
            FINAL: begin
                nxt  = mm_done ? IDLE : FINAL;
                done = mm_done;
            end
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m      <= '0;
            e      <= '0;
            n      <= '0;
            res    <= '0;
            a      <= '0;
            t      <= '0;
            x      <= '0;
            cnt    <= '0;
            k      <= '0;
            err_q  <= 1'b0;
            data_o <= 8'h00;
        end else begin
            if (wr_ok && reg_sel == RSEL_M) m[bo +: 8] <= data_i;
            if (wr_ok && reg_sel == RSEL_E) e[bo +: 8] <= data_i;
            if (wr_ok && reg_sel == RSEL_N) n[bo +: 8] <= data_i;
            if (!oe) data_o <= (reg_sel == RSEL_RES && addr_ok) ? res[bo +: 8] : 8'h00;
            if (state == IDLE && start) err_q <= 1'b0;
            else if (state == CHECK && !n[0]) err_q <= 1'b1;
            // N==1 starts from 0 so every residue stays below N
            if (state == CHECK) x <= W'(n != W'(1));
            else if (state == PRE) x <= x_next;
            if (state == PRE && cnt == CW'(W - 1)) a <= x_next;
            else if (state == EXP && mm_done && e[k]) a <= r0;
            if (state == PRE && cnt == CW'(2 * W - 1)) t <= x_next;
            else if (state == TOMONT && mm_done) t <= r0;
            else if (state == EXP && mm_done) t <= r1;
            if (state == FINAL && mm_done) res <= r0;
            k   <= state != EXP ? '0 : (mm_done ? k + KW'(1) : k);
            cnt <= (state == IDLE || nxt != state || mm_done) ? '0 : cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core: directed and random checks of two core widths against a plain-arithmetic model
module tb_rsa_modexp_core;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    logic       we_s[2], oe_s[2], start_s[2];
    logic [1:0] sel_s[2];
    logic [7:0] addr_s[2], din_s[2];
    logic [7:0] dout0, dout1, dout_s[2];
    logic       busy0, busy1, done0, done1, err0, err1;
    logic       busy_s[2], done_s[2], err_s[2];
    int         wid[2] = '{16, 32};
    int         nb[2]  = '{2, 4};
    int         checks = 0, errors = 0;
    always_comb begin
        dout_s[0] = dout0; dout_s[1] = dout1;
        busy_s[0] = busy0; busy_s[1] = busy1;
        done_s[0] = done0; done_s[1] = done1;
        err_s[0]  = err0;  err_s[1]  = err1;
    end
    rsa_modexp_core #(.W(16)) d16 (
        .clk(clk), .reset(rst_n), .we(we_s[0]), .oe(oe_s[0]), .reg_sel(sel_s[0]),
        .addr(addr_s[0][0:0]), .data_i(din_s[0]), .data_o(dout0), .start(start_s[0]),
        .busy(busy0), .done(done0), .error(err0)
    );
    rsa_modexp_core #(.W(32)) d32 (
        .clk(clk), .reset(rst_n), .we(we_s[1]), .oe(oe_s[1]), .reg_sel(sel_s[1]),
        .addr(addr_s[1][1:0]), .data_i(din_s[1]), .data_o(dout1), .start(start_s[1]),
        .busy(busy1), .done(done1), .error(err1)
    );
    function automatic int lat(int w);
        return 1 + 2 * w + (w + 2) * (w + 2);
    endfunction
    function automatic logic [63:0] modexp(logic [63:0] mv, logic [63:0] ev, logic [63:0] nv, int w);
        logic [63:0] r, b;
        if (nv == 64'd1) return 64'd0;
        r = 64'd1;
        b = mv % nv;
        for (int i = 0; i < w; i++) begin
            if (ev[i]) r = (r * b) % nv;
            b = (b * b) % nv;
        end
        return r;
    endfunction
    task automatic chk(string nm, int d, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, d, got, want, $time);
        end
    endtask
    // model: shadow registers, busy countdown, result computed by plain square-and-multiply
    logic [63:0] m_sh[2], e_sh[2], n_sh[2], res_m[2];
    logic [7:0]  dout_m[2];
    logic        err_m[2], odd_run[2];
    int          rem[2];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                m_sh[d] <= '0; e_sh[d] <= '0; n_sh[d] <= '0; res_m[d] <= '0;
                dout_m[d] <= '0; err_m[d] <= 1'b0; odd_run[d] <= 1'b0; rem[d] <= 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!oe_s[d]) dout_m[d] <= sel_s[d] == 2'd0 ? res_m[d][8 * (int'(addr_s[d]) % nb[d]) +: 8] : 8'h00;
                if (rem[d] == 0 && !we_s[d]) begin
                    if (sel_s[d] == 2'd1) m_sh[d][8 * (int'(addr_s[d]) % nb[d]) +: 8] <= din_s[d];
                    if (sel_s[d] == 2'd2) e_sh[d][8 * (int'(addr_s[d]) % nb[d]) +: 8] <= din_s[d];
                    if (sel_s[d] == 2'd3) n_sh[d][8 * (int'(addr_s[d]) % nb[d]) +: 8] <= din_s[d];
                end
                if (rem[d] == 0 && start_s[d]) begin
                    rem[d]     <= n_sh[d][0] ? lat(wid[d]) : 1;
                    odd_run[d] <= n_sh[d][0];
                    err_m[d]   <= !n_sh[d][0];
                end else if (rem[d] > 0) begin
                    rem[d] <= rem[d] - 1;
                    if (rem[d] == 1 && odd_run[d]) res_m[d] <= modexp(m_sh[d], e_sh[d], n_sh[d], wid[d]);
                end
            end
        end
    end
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk("busy", d, 64'(busy_s[d]), 64'(rem[d] > 0));
            chk("done", d, 64'(done_s[d]), 64'(rem[d] == 1));
            chk("error", d, 64'(err_s[d]), 64'(err_m[d]));
            chk("data_o", d, 64'(dout_s[d]), 64'(dout_m[d]));
        end
    end
    task automatic wr(int d, logic [1:0] sel, logic [63:0] v);
        for (int i = 0; i < nb[d]; i++) begin
            we_s[d] = 1'b0; sel_s[d] = sel; addr_s[d] = 8'(i); din_s[d] = v[8 * i +: 8];
            @(posedge clk); #1;
        end
        we_s[d] = 1'b1;
    endtask
    task automatic setup(int d, logic [63:0] nv, logic [63:0] mv, logic [63:0] ev);
        wr(d, 2'd3, nv);
        wr(d, 2'd1, mv);
        wr(d, 2'd2, ev);
    endtask
    task automatic rd_res(int d, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < nb[d]; i++) begin
            oe_s[d] = 1'b0; sel_s[d] = 2'd0; addr_s[d] = 8'(i);
            @(posedge clk); #1;
            v[8 * i +: 8] = dout_s[d];
        end
        oe_s[d] = 1'b1;
    endtask
    // start, then count busy cycles and done pulses; mid=1 pokes a write and a start while busy
    task automatic run(int d, int exp_lat, bit mid);
        int cyc, ndone, dpos;
        cyc = 0; ndone = 0; dpos = 0;
        start_s[d] = 1'b1;
        @(posedge clk); #1;
        start_s[d] = 1'b0;
        while (busy_s[d] && cyc < exp_lat + 20) begin
            if (done_s[d]) begin ndone++; dpos = cyc + 1; end
            if (mid && cyc == 50) begin
                start_s[d] = 1'b1; we_s[d] = 1'b0; sel_s[d] = 2'd1; addr_s[d] = 8'd0; din_s[d] = 8'hFF;
            end else begin
                start_s[d] = 1'b0; we_s[d] = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start_s[d] = 1'b0; we_s[d] = 1'b1;
        chk("latency", d, 64'(cyc), 64'(exp_lat));
        chk("done_count", d, 64'(ndone), 64'd1);
        chk("done_pos", d, 64'(dpos), 64'(exp_lat));
    endtask
    initial begin
        logic [63:0] v, nn, mm, ee;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            we_s[d] = 1'b1; oe_s[d] = 1'b1; start_s[d] = 1'b0;
            sel_s[d] = 2'd0; addr_s[d] = 8'd0; din_s[d] = 8'd0;
        end
        #12;
        chk("rst_busy", 0, 64'(busy0), 64'd0);
        chk("rst_done", 0, 64'(done0), 64'd0);
        chk("rst_error", 0, 64'(err0), 64'd0);
        chk("rst_data_o", 0, 64'(dout0), 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        rd_res(0, v); chk("rst_res", 0, v, 64'h0);
        setup(0, 64'h0D, 64'h4, 64'h3); run(0, 357, 1'b0);
        rd_res(0, v); chk("res_4_3_13", 0, v, 64'h000C);
        chk("model_pin_13", 0, res_m[0], 64'h0C);
        setup(0, 64'h3E9, 64'h2, 64'hA); run(0, 357, 1'b0);
        rd_res(0, v); chk("res_2_10_1001", 0, v, 64'h0017);
        chk("model_pin_1001", 0, res_m[0], 64'h17);
        wr(0, 2'd3, 64'h10); run(0, 1, 1'b0);
        chk("even_error", 0, 64'(err0), 64'd1);
        rd_res(0, v); chk("even_res_kept", 0, v, 64'h0017);
        setup(0, 64'h3E9, 64'h0, 64'hA);
        start_s[0] = 1'b1; @(posedge clk); #1; start_s[0] = 1'b0;
        chk("error_cleared", 0, 64'(err0), 64'd0);
        repeat (400) if (busy0) begin @(posedge clk); #1; end
        rd_res(0, v); chk("res_m0", 0, v, 64'h0000);
        setup(0, 64'h3E9, 64'h2, 64'h0); run(0, 357, 1'b0);
        rd_res(0, v); chk("res_e0", 0, v, 64'h0001);
        setup(0, 64'h1, 64'h0, 64'h5); run(0, 357, 1'b0);
        rd_res(0, v); chk("res_n1", 0, v, 64'h0000);
        setup(0, 64'h3E9, 64'h2, 64'hA); run(0, 357, 1'b1);
        rd_res(0, v); chk("res_mid_ignored", 0, v, 64'h0017);
        setup(0, 64'h0D, 64'h4, 64'h3);
        start_s[0] = 1'b1; @(posedge clk); #1; start_s[0] = 1'b0;
        repeat (9) @(posedge clk); #1;
        oe_s[0] = 1'b0; sel_s[0] = 2'd0; addr_s[0] = 8'd0;
        @(posedge clk); #1;
        oe_s[0] = 1'b1;
        chk("read_while_busy", 0, 64'(dout0), 64'h17);
        repeat (89) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 0, 64'(busy0), 64'd0);
        chk("midrst_data_o", 0, 64'(dout0), 64'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        rd_res(0, v); chk("midrst_res", 0, v, 64'h0);
        setup(0, 64'h0D, 64'h4, 64'h3); run(0, 357, 1'b0);
        rd_res(0, v); chk("after_rst_res", 0, v, 64'h000C);
        for (int i = 0; i < 6; i++) begin
            nn = 64'($urandom_range(65535, 3)) | 64'h1;
            mm = 64'($urandom) % nn;
            ee = 64'($urandom_range(65535, 0));
            setup(0, nn, mm, ee); run(0, 357, 1'b0);
            rd_res(0, v); chk("rand16", 0, v, modexp(mm, ee, nn, 16));
        end
        setup(1, 64'h3E9, 64'h2, 64'hA); run(1, lat(32), 1'b0);
        rd_res(1, v); chk("res32_2_10_1001", 1, v, 64'h00000017);
        for (int i = 0; i < 8; i++) begin
            nn = 64'($urandom) | 64'h1;
            if (nn < 64'd3) nn = 64'd3;
            mm = 64'($urandom) % nn;
            ee = 64'($urandom);
            setup(1, nn, mm, ee); run(1, lat(32), 1'b0);
            rd_res(1, v); chk("rand32", 1, v, modexp(mm, ee, nn, 32));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
